fetch_stage: RTL

//   Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode-stage control unit.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage_if_id.sv | 29 ++
 rtl/fetch_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: FSM encodings, IF/ID record, reset values.
// Also reused by the decode-side control unit for instruction-width constants.
package fetch_stage_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned INSTR_W       = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc_plus4;
        logic               valid;
    } ifid_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: decode control in, instruction-memory handshake, IF/ID outputs.
// master = fetch stage view, slave = decode/hazard/memory side.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic               stallD;
    logic               pcSrcD;
    logic [XLEN-1:0]    pcBranchD;
    logic               imemReq;
    logic [XLEN-1:0]    imemAddr;
    logic               imemAck;
    logic [INSTR_W-1:0] imemRdata;
    logic [INSTR_W-1:0] instrD;
    logic [XLEN-1:0]    pcPlus4D;
    logic               validD;

    modport master (
        input  stallD, pcSrcD, pcBranchD, imemAck, imemRdata,
        output imemReq, imemAddr, instrD, pcPlus4D, validD
    );

    modport slave (
        output stallD, pcSrcD, pcBranchD, imemAck, imemRdata,
        input  imemReq, imemAddr, instrD, pcPlus4D, validD
    );

endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register with priority flush > hold > load; flush inserts a NOP bubble.
// Latency: 1 cycle from load to output.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  hold,
    input  logic  load,
    input  ifid_t din,
    output ifid_t q
);

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (!hold && load) begin
            q <= din;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request, one-word skid buffer, IF/ID register.
// Zero-wait memory sustains one instruction per cycle; a stall during an ack parks the word in HOLD.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master fs
);

    fetch_state_t       state_q, state_d;
    logic               req_en;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    redir_pc_q;
    logic [INSTR_W-1:0] buf_instr_q;
    logic [XLEN-1:0]    buf_pc4_q;
    logic               buf_vld_q;
    logic [XLEN-1:0]    target;
    logic               unused_target_bits;

    logic               imem_req;
    logic               fire;
    logic               drain_go;
    logic               ifid_flush;
    logic               ifid_hold;
    logic               ifid_load;
    ifid_t              ifid_din;
    ifid_t              ifid_q;

    assign target             = {fs.pcBranchD[XLEN-1:2], 2'b00};
    assign unused_target_bits = ^fs.pcBranchD[1:0];

    // First request goes out on the cycle after the first clock edge following reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_en <= 1'b0;
        else     req_en <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fs.pcSrcD) begin
            state_d = drain_go ? DRAIN : FETCH;
        end else begin
            case (state_q)
                FETCH:   if (fire && fs.stallD) state_d = HOLD;
                HOLD:    if (!fs.stallD)        state_d = FETCH;
                DRAIN:   if (fire)              state_d = FETCH;
                default:                        state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req  = req_en && (state_q != HOLD);
        fire      = imem_req && fs.imemAck;
        drain_go  = fs.pcSrcD && imem_req && !fs.imemAck;
        ifid_load = 1'b0;
        ifid_din  = '{instr: fs.imemRdata, pc_plus4: pc_plus4(pc_q), valid: 1'b1};
        case (state_q)
            FETCH: ifid_load = fire && !fs.stallD;
            HOLD: begin
                ifid_load = buf_vld_q && !fs.stallD;
                ifid_din  = '{instr: buf_instr_q, pc_plus4: buf_pc4_q, valid: 1'b1};
            end
            default: ifid_load = 1'b0;
        endcase
        // Anything that is neither a load nor a stall leaves a bubble in IF/ID.
        ifid_flush = fs.pcSrcD || (!fs.stallD && !ifid_load);
        ifid_hold  = fs.stallD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            redir_pc_q  <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            buf_pc4_q   <= '0;
            buf_vld_q   <= 1'b0;
        end else if (fs.pcSrcD) begin
            if (drain_go) redir_pc_q <= target;
            else          pc_q       <= target;
            buf_vld_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (fire) pc_q <= pc_plus4(pc_q);
                    if (fire && fs.stallD) begin
                        buf_instr_q <= fs.imemRdata;
                        buf_pc4_q   <= pc_plus4(pc_q);
                        buf_vld_q   <= 1'b1;
                    end
                end
                HOLD:    if (!fs.stallD) buf_vld_q <= 1'b0;
                DRAIN:   if (fire) pc_q <= redir_pc_q;
                default: ;
            endcase
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .flush (ifid_flush),
        .hold  (ifid_hold),
        .load  (ifid_load),
        .din   (ifid_din),
        .q     (ifid_q)
    );

    assign fs.imemReq  = imem_req;
    assign fs.imemAddr = pc_q;
    assign fs.instrD   = ifid_q.instr;
    assign fs.pcPlus4D = ifid_q.pc_plus4;
    assign fs.validD   = ifid_q.valid;

endmodule
